beam_envelope_buffer: RTL and testbench

- Downstream stage of the 8-channel delay-and-sum beamformer; consumes one frame of 36-bit signed summed beam samples (540 per frame).
- Per sample: rectify, scale, saturate to 16-bit magnitude, store in a frame buffer, and track the frame peak and its index.
- After capture, streams the buffered frame out over a valid/ready interface to the display/host stage, then pulses frame_done.

---
 rtl/beamformer_pkg.sv | 21 ++
 rtl/beam_mag_ram.sv | 36 +++
 rtl/beam_envelope_buffer.sv | 170 +++++++++++++++++
 tb/tb_beam_envelope_buffer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beamformer_pkg.sv
// ============================================================================
// Module  : beamformer_pkg
// Brief   : Shared widths and envelope-buffer state encoding for the beamformer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package beamformer_pkg;
    localparam int C_DATA_W = 36;
    localparam int C_OUT_W  = 16;
    localparam int C_DEPTH  = 540;
    localparam int C_ADDR_W = 10;
    localparam int C_SHIFT  = 8;

    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_CAPTURE = 2'd1;
    localparam logic [1:0] C_ST_READOUT = 2'd2;
    localparam logic [1:0] C_ST_DONE    = 2'd3;
endpackage

`default_nettype wire

// File: rtl/beam_mag_ram.sv
// ============================================================================
// Module  : beam_mag_ram
// Brief   : Simple dual-port RAM, one write port, one registered read port.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module beam_mag_ram #(
    parameter int DEPTH  = 540,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/beam_envelope_buffer.sv
// ============================================================================
// Module  : beam_envelope_buffer
// Brief   : Rectify/scale/saturate beam samples, buffer a frame, track the
//           peak, then stream the frame out over valid/ready.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module beam_envelope_buffer
    import beamformer_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int OUT_W  = C_OUT_W,
    parameter int DEPTH  = C_DEPTH,
    parameter int ADDR_W = C_ADDR_W,
    parameter int SHIFT  = C_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [OUT_W-1:0]         peak_value,
    output logic [ADDR_W-1:0]        peak_index,
    output logic [ADDR_W:0]          frame_len,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overflow
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W:0]   r_frame_len;
    logic [OUT_W-1:0]  r_peak_value;
    logic [ADDR_W-1:0] r_peak_index;
    logic              r_out_valid;
    logic              r_overflow;

    logic [DATA_W-1:0] w_abs;
    logic [DATA_W-1:0] w_shifted;
    logic [OUT_W-1:0]  w_mag;
    logic [OUT_W-1:0]  w_rdata;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_we;
    logic              w_cap_end;
    logic              w_hs;
    logic              w_last_rd;

    // The most-negative sample has no positive twin; clamp it to max positive.
    always_comb begin
        w_abs = in_data;
        if (in_data[DATA_W-1]) begin
            if (in_data == {1'b1, {(DATA_W-1){1'b0}}}) begin
                w_abs = {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                w_abs = -in_data;
            end
        end
        w_shifted = w_abs >> SHIFT;
        if (|w_shifted[DATA_W-1:OUT_W]) begin
            w_mag = '1;
        end else begin
            w_mag = w_shifted[OUT_W-1:0];
        end
    end

    assign w_we      = (r_state == C_ST_CAPTURE) && in_valid;
    assign w_cap_end = w_we && ((r_wr_ptr == ADDR_W'(DEPTH - 1)) || in_last);
    assign w_hs      = r_out_valid && out_ready;
    assign w_last_rd = ({1'b0, r_out_addr} == (r_frame_len - (ADDR_W+1)'(1)));

    // Read address tracks the presented sample so the RAM output holds during a stall.
    assign w_rd_addr = (w_hs && !w_last_rd) ? (r_out_addr + ADDR_W'(1)) : r_out_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= C_ST_IDLE;
            r_wr_ptr     <= '0;
            r_out_addr   <= '0;
            r_frame_len  <= '0;
            r_peak_value <= '0;
            r_peak_index <= '0;
            r_out_valid  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (frame_start) begin
                        r_state      <= C_ST_CAPTURE;
                        r_wr_ptr     <= '0;
                        r_out_addr   <= '0;
                        r_frame_len  <= '0;
                        r_peak_value <= '0;
                        r_peak_index <= '0;
                        r_overflow   <= 1'b0;
                    end
                end
                C_ST_CAPTURE: begin
                    if (w_we) begin
                        r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
                        r_frame_len <= {1'b0, r_wr_ptr} + (ADDR_W+1)'(1);
                        if (w_mag > r_peak_value) begin
                            r_peak_value <= w_mag;
                            r_peak_index <= r_wr_ptr;
                        end
                    end
                    if (w_cap_end) begin
                        r_state    <= C_ST_READOUT;
                        r_out_addr <= '0;
                    end
                end
                C_ST_READOUT: begin
                    if (in_valid) begin
                        r_overflow <= 1'b1;
                    end
                    // First cycle here primes the RAM read of address 0.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (w_hs) begin
                        if (w_last_rd) begin
                            r_out_valid <= 1'b0;
                            r_state     <= C_ST_DONE;
                        end else begin
                            r_out_addr <= r_out_addr + ADDR_W'(1);
                        end
                    end
                end
                C_ST_DONE: begin
                    if (in_valid) begin
                        r_overflow <= 1'b1;
                    end
                    r_state <= C_ST_IDLE;
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

    beam_mag_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (OUT_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_mag),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_valid ? w_rdata : '0;
    assign out_addr   = r_out_addr;
    assign peak_value = r_peak_value;
    assign peak_index = r_peak_index;
    assign frame_len  = r_frame_len;
    assign busy       = (r_state == C_ST_CAPTURE) || (r_state == C_ST_READOUT);
    assign frame_done = (r_state == C_ST_DONE);
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_beam_envelope_buffer.sv
// ============================================================================
// Module  : tb_beam_envelope_buffer
// Brief   : Randomized scoreboard bench for beam_envelope_buffer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beam_envelope_buffer;

    localparam longint C_MAXP = 64'sd34359738367;   // 2^35 - 1

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               frame_start = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [35:0] in_data = '0;
    logic               in_last = 1'b0;
    logic               out_ready = 1'b1;
    logic               out_valid;
    logic [15:0]        out_data;
    logic [9:0]         out_addr;
    logic [15:0]        peak_value;
    logic [9:0]         peak_index;
    logic [10:0]        frame_len;
    logic               busy;
    logic               frame_done;
    logic               overflow;

    beam_envelope_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .peak_value  (peak_value),
        .peak_index  (peak_index),
        .frame_len   (frame_len),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t   exp_q[$];
    longint frame[$];
    int     checks = 0;
    int     errors = 0;
    int     hs_cnt = 0;
    int     done_cnt = 0;
    int     ready_mode = 0;
    int     rdy_k = 0;
    logic   prev_stall = 1'b0;
    int     prev_data = 0;
    int     prev_addr = 0;
    exp_t   mon_e;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int ref_mag(longint v);
        longint a;
        a = (v < 0) ? -v : v;
        if (a > C_MAXP) a = C_MAXP;
        a = a / 256;
        if (a > 65535) a = 65535;
        return int'(a);
    endfunction

    function automatic longint gen_val();
        longint v;
        case ($urandom % 8)
            0: v = -(C_MAXP + 1);
            1: v = C_MAXP;
            2: v = 0;
            default: begin
                v = longint'($urandom_range(0, 24'hFFFFFF));
                if ($urandom % 2) v = -v;
            end
        endcase
        return v;
    endfunction

    // Output monitor: pops the scoreboard on every handshake, checks holds on stall.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (frame_done) done_cnt++;
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_addr", out_addr, prev_addr);
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output_addr", out_addr, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_addr", out_addr, mon_e.addr);
                    chk("out_data", out_data, mon_e.data);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_addr  = out_addr;
        end
    end

    // Downstream ready pattern generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = ((rdy_k % 4) == 0) || ((rdy_k % 4) == 3);
                    rdy_k++;
                end
                default: out_ready = 1'($urandom % 2);
            endcase
        end
    end

    task automatic send(longint v, bit last, int idx, int max_gap);
        int g;
        g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = v[35:0];
        in_last  = last;
        exp_q.push_back(exp_t'{addr: idx, data: ref_mag(v)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic start_frame(int rmode);
        ready_mode = rmode;
        hs_cnt     = 0;
        done_cnt   = 0;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        chk("overflow_cleared", overflow, 0);
        chk("busy_in_capture", busy, 1);
    endtask

    task automatic run_frame(bit use_last, int max_gap, int rmode, bit inject);
        int n;
        int pk;
        int pk_idx;
        int got;
        n = frame.size();
        pk = 0;
        pk_idx = 0;
        for (int i = 0; i < n; i++) begin
            if (ref_mag(frame[i]) > pk) begin
                pk = ref_mag(frame[i]);
                pk_idx = i;
            end
        end
        start_frame(rmode);
        for (int i = 0; i < n; i++) begin
            send(frame[i], use_last && (i == n - 1), i, max_gap);
        end
        if (inject) begin
            got = 0;
            for (int c = 0; c < 20; c++) begin
                if (out_valid) begin
                    got = 1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            chk("readout_started", got, 1);
            for (int j = 0; j < 3; j++) begin
                in_valid    = 1'b1;
                in_data     = 36'(gen_val());
                frame_start = (j == 0);
                @(posedge clk);
                #1;
            end
            in_valid    = 1'b0;
            frame_start = 1'b0;
        end
        got = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (frame_done) begin
                got = 1;
                break;
            end
        end
        chk("frame_done_seen", got, 1);
        repeat (3) @(negedge clk);
        chk("frame_done_pulses", done_cnt, 1);
        chk("handshakes", hs_cnt, n);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("frame_len", frame_len, n);
        chk("peak_value", peak_value, pk);
        chk("peak_index", peak_index, pk_idx);
        chk("busy_idle", busy, 0);
        chk("overflow", overflow, inject);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_peak_value", peak_value, 0);
        chk("rst_frame_done", frame_done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full ramp frame, ready held high.
        frame.delete();
        for (int i = 0; i < 540; i++) frame.push_back(longint'(i) * 256);
        run_frame(1'b0, 0, 0, 1'b0);

        // Sign, most-negative, saturation and truncation cases.
        frame.delete();
        frame.push_back(-256);
        frame.push_back(-(C_MAXP + 1));
        frame.push_back(64'sd1073741824);
        frame.push_back(255);
        run_frame(1'b1, 1, 1, 1'b0);

        // Short frame with 1,0,0,1 backpressure.
        frame.delete();
        for (int i = 0; i < 100; i++) frame.push_back(gen_val());
        run_frame(1'b1, 2, 1, 1'b0);

        // Stray input and frame_start during readout.
        frame.delete();
        for (int i = 0; i < 50; i++) frame.push_back(gen_val());
        run_frame(1'b1, 1, 2, 1'b1);

        // Asynchronous reset in the middle of capture.
        start_frame(0);
        for (int i = 0; i < 200; i++) send(gen_val(), 1'b0, i, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_len", frame_len, 0);
        chk("midrst_peak_value", peak_value, 0);
        chk("midrst_peak_index", peak_index, 0);
        chk("midrst_out_addr", out_addr, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_overflow", overflow, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Random frames, including single-sample and in_last at the final slot.
        for (int f = 0; f < 4; f++) begin
            case (f)
                0: n = 1;
                1: n = 540;
                default: n = $urandom_range(2, 300);
            endcase
            frame.delete();
            for (int i = 0; i < n; i++) frame.push_back(gen_val());
            run_frame(1'b1, $urandom_range(0, 2), f % 3, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
